// File: rtl/pck_dbus.sv
// pck_dbus: shared state encoding and limits for the data-bus RAM responder.
package pck_dbus;
   localparam int DBUS_MAX_WAIT = 15;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} dbus_resp_state_e;
endpackage

// File: rtl/ram_sp_be.sv
// ram_sp_be: single-port synchronous RAM with byte-enable write and registered read.
module ram_sp_be #(
   parameter int p_depth = 1024
) (
   input  logic                       i_clk,
   input  logic                       en,
   input  logic                       we,
   input  logic [3:0]                 be,
   input  logic [$clog2(p_depth)-1:0] addr,
   input  logic [31:0]                wr_data,
   output logic [31:0]                rd_data
);
   logic [31:0] mem [p_depth];
   always_ff @(posedge i_clk) begin
      if (en && we)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
      if (en && !we) rd_data <= mem[addr];
   end
endmodule

// File: rtl/dbus_ram_resp.sv
// dbus_ram_resp: data-bus responder backed by a byte-enable RAM with programmable wait states.
module dbus_ram_resp
   import pck_dbus::*;
#(
   parameter int p_depth       = 1024,
   parameter int p_wait_states = 0
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] dbus_addr,
   input  logic [3:0]  dbus_be,
   input  logic        dbus_wr_en,
   input  logic [31:0] dbus_wr_data,
   input  logic        dbus_rd_en,
   output logic [31:0] dbus_rd_data,
   output logic        dbus_busy,
   output logic        dbus_ack,
   output logic        o_addr_err
);
   localparam int aw = $clog2(p_depth);
   localparam int cw = $clog2(DBUS_MAX_WAIT + 1);
   localparam bit wait0 = (p_wait_states == 0);
   dbus_resp_state_e state, nxt;
   logic [cw-1:0] cnt;
   logic [29:0]   c_idx, idx;
   logic [3:0]    c_be, be;
   logic [31:0]   c_data, wdata, ram_q, rd_hold;
   logic          c_wr, c_oor, wr, oor, accept, go_resp, ram_en;
   logic          unused_addr_lsb;
   assign unused_addr_lsb = ^dbus_addr[1:0];
   // Outside WAIT the RAM sees the live request so a zero-wait access commits on its accept edge.
   always_comb begin
      accept       = (dbus_rd_en | dbus_wr_en) && state != WAIT;
      idx          = (state == WAIT) ? c_idx : dbus_addr[31:2];
      be           = (state == WAIT) ? c_be : dbus_be;
      wdata        = (state == WAIT) ? c_data : dbus_wr_data;
      wr           = (state == WAIT) ? c_wr : dbus_wr_en;
      oor          = idx >= 30'(p_depth);
      go_resp      = (accept && wait0) || (state == WAIT && cnt == cw'(1));
      ram_en       = go_resp && !oor && !i_rst;
      nxt          = IDLE;
      if (state == WAIT) nxt = (cnt == cw'(1)) ? RESP : WAIT;
      else if (accept) nxt = wait0 ? RESP : WAIT;
      dbus_busy    = state == WAIT;
      dbus_ack     = state == RESP;
      dbus_rd_data = (state == RESP && !c_wr) ? (c_oor ? 32'h0 : ram_q) : rd_hold;
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         rd_hold    <= 32'h0;
         o_addr_err <= 1'b0;
      end else begin
         state   <= nxt;
         rd_hold <= dbus_rd_data;
         if (go_resp && oor) o_addr_err <= 1'b1;
      end
      cnt <= (state == WAIT) ? cnt - cw'(1) : cw'(p_wait_states);
      if (accept) begin
         c_idx  <= idx;
         c_be   <= be;
         c_data <= wdata;
         c_wr   <= wr;
         c_oor  <= oor;
      end
   end
   ram_sp_be #(.p_depth(p_depth)) u_ram (
      .i_clk   (i_clk),
      .en      (ram_en),
      .we      (wr),
      .be      (be),
      .addr    (idx[aw-1:0]),
      .wr_data (wdata),
      .rd_data (ram_q)
   );
endmodule

// File: tb/tb_dbus_ram_resp.sv
// tb_dbus_ram_resp: directed checks of three responder instances (0, 3 and 2 wait states).
module tb_dbus_ram_resp;
   logic        i_clk = 1'b0;
   logic        rst[3];
   logic [31:0] addr[3], wr_data[3], rd_data[3];
   logic [3:0]  be[3];
   logic        wr_en[3], rd_en[3], busy[3], ack[3], err[3];
   int          n_chk = 0, n_pass = 0;
   always #5 i_clk = ~i_clk;
   for (genvar g = 0; g < 3; g++) begin : g_dut
      dbus_ram_resp #(.p_depth(1024), .p_wait_states(g == 0 ? 0 : g == 1 ? 3 : 2)) u_dut (
         .i_clk        (i_clk),
         .i_rst        (rst[g]),
         .dbus_addr    (addr[g]),
         .dbus_be      (be[g]),
         .dbus_wr_en   (wr_en[g]),
         .dbus_wr_data (wr_data[g]),
         .dbus_rd_en   (rd_en[g]),
         .dbus_rd_data (rd_data[g]),
         .dbus_busy    (busy[g]),
         .dbus_ack     (ack[g]),
         .o_addr_err   (err[g])
      );
   end
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   task automatic drive(int i, bit r, bit w, logic [31:0] a, logic [3:0] b, logic [31:0] d);
      rd_en[i] = r;
      wr_en[i] = w;
      addr[i] = a;
      be[i] = b;
      wr_data[i] = d;
   endtask
   task automatic tick();
      @(posedge i_clk);
      @(negedge i_clk);
   endtask
   // Zero-wait transfer: present at a falling edge, accepted next rising edge, response checked one cycle later.
   task automatic xfer0(string tag, bit r, bit w, logic [31:0] a, logic [3:0] b, logic [31:0] d);
      drive(0, r, w, a, b, d);
      tick();
      chk({tag, "_ack"}, ack[0], 1);
      chk({tag, "_busy"}, busy[0], 0);
   endtask
   initial begin
      for (int i = 0; i < 3; i++) begin
         rst[i] = 1'b1;
         drive(i, 0, 0, 0, 0, 0);
      end
      @(negedge i_clk);
      repeat (2) tick();
      for (int i = 0; i < 3; i++) begin
         chk("rst_ack", ack[i], 0);
         chk("rst_busy", busy[i], 0);
         chk("rst_rd_data", rd_data[i], 0);
         chk("rst_err", err[i], 0);
         rst[i] = 1'b0;
      end
      xfer0("w_beef", 0, 1, 32'h10, 4'hf, 32'hdeadbeef);
      xfer0("r_beef", 1, 0, 32'h10, 4'h0, 32'h0);
      chk("r_beef_data", rd_data[0], 32'hdeadbeef);
      drive(0, 0, 0, 0, 0, 0);
      tick();
      chk("idle_ack", ack[0], 0);
      chk("hold_data", rd_data[0], 32'hdeadbeef);
      xfer0("w_aabb", 0, 1, 32'h20, 4'hf, 32'haabbccdd);
      chk("w_keeps_data", rd_data[0], 32'hdeadbeef);
      xfer0("w_lane2", 0, 1, 32'h20, 4'b0100, 32'h00110000);
      xfer0("w_be0", 0, 1, 32'h20, 4'b0000, 32'hffffffff);
      xfer0("r_lane", 1, 0, 32'h20, 4'h0, 32'h0);
      chk("r_lane_data", rd_data[0], 32'haa11ccdd);
      xfer0("rw_both", 1, 1, 32'h4, 4'hf, 32'h12345678);
      chk("rw_both_data", rd_data[0], 32'haa11ccdd);
      xfer0("r_both", 1, 0, 32'h4, 4'h0, 32'h0);
      chk("r_both_data", rd_data[0], 32'h12345678);
      chk("err_clear", err[0], 0);
      xfer0("r_oor", 1, 0, 32'h1000, 4'h0, 32'h0);
      chk("r_oor_data", rd_data[0], 32'h0);
      chk("r_oor_err", err[0], 1);
      xfer0("w_oor", 0, 1, 32'h1010, 4'hf, 32'hffffffff);
      xfer0("r_alias", 1, 0, 32'h10, 4'h0, 32'h0);
      chk("r_alias_data", rd_data[0], 32'hdeadbeef);
      drive(0, 0, 0, 0, 0, 0);
      repeat (3) tick();
      chk("err_sticky", err[0], 1);
      rst[0] = 1'b1;
      tick();
      rst[0] = 1'b0;
      chk("err_reset", err[0], 0);
      // Three wait states: busy in cycles 1-3, ack in cycle 4; a request during cycle 2 must be dropped.
      drive(1, 0, 1, 32'h8, 4'hf, 32'h55aa55aa);
      for (int c = 1; c <= 5; c++) begin
         tick();
         drive(1, 0, 0, 0, 0, 0);
         if (c == 2) drive(1, 1, 0, 32'h8, 4'h0, 32'h0);
         chk($sformatf("w3_wr_busy_c%0d", c), busy[1], c <= 3);
         chk($sformatf("w3_wr_ack_c%0d", c), ack[1], c == 4);
      end
      drive(1, 1, 0, 32'h8, 4'h0, 32'h0);
      for (int c = 1; c <= 4; c++) begin
         tick();
         drive(1, 0, 0, 0, 0, 0);
         chk($sformatf("w3_rd_busy_c%0d", c), busy[1], c <= 3);
         chk($sformatf("w3_rd_ack_c%0d", c), ack[1], c == 4);
      end
      chk("w3_rd_data", rd_data[1], 32'h55aa55aa);
      // Two wait states: reset while a write is pending must abandon it.
      drive(2, 0, 1, 32'hc, 4'hf, 32'h11111111);
      tick();
      drive(2, 0, 0, 0, 0, 0);
      repeat (2) tick();
      chk("w2_first_ack", ack[2], 1);
      drive(2, 0, 1, 32'hc, 4'hf, 32'h22222222);
      tick();
      drive(2, 0, 0, 0, 0, 0);
      chk("w2_busy_before_rst", busy[2], 1);
      rst[2] = 1'b1;
      tick();
      rst[2] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("w2_abandon_ack_%0d", c), ack[2], 0);
         chk($sformatf("w2_abandon_busy_%0d", c), busy[2], 0);
         tick();
      end
      drive(2, 1, 0, 32'hc, 4'h0, 32'h0);
      tick();
      drive(2, 0, 0, 0, 0, 0);
      repeat (2) tick();
      chk("w2_rd_ack", ack[2], 1);
      chk("w2_rd_old", rd_data[2], 32'h11111111);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/dbus_ram_resp.md
DBUS_RAM_RESP -- requirements
Module: dbus_ram_resp

Interface
REQ-001 SHALL have parameter p_depth, default 1024, RAM size in 32-bit words (power of two, >= 2).
REQ-002 SHALL have parameter p_wait_states, default 0, wait cycles per access (0..15).
REQ-003 SHALL use one clock, with a synchronous, active-high reset.
REQ-004 SHALL have port i_clk, input, 1 bit: global clock, rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port dbus_addr, input, 32 bits: word-aligned byte address (bits [1:0] ignored).
REQ-007 SHALL have port dbus_be, input, 4 bits: write byte enables, bit k -> byte lane k (bits 8k+7:8k).
REQ-008 SHALL have port dbus_wr_en, input, 1 bit: write request.
REQ-009 SHALL have port dbus_wr_data, input, 32 bits: lane-aligned write data.
REQ-010 SHALL have port dbus_rd_en, input, 1 bit: read request.
REQ-011 SHALL have port dbus_rd_data, output, 32 bits: full read word (initiator aligns/extends).
REQ-012 SHALL have port dbus_busy, output, 1 bit: request not accepted this cycle.
REQ-013 SHALL have port dbus_ack, output, 1 bit: single-cycle transfer-complete pulse.
REQ-014 SHALL have port o_addr_err, output, 1 bit: sticky, set on out-of-range access.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL accept a request when (dbus_rd_en | dbus_wr_en) is high and dbus_busy is low in IDLE or RESP, capturing addr, be, wr_data and op.
REQ-017 SHALL, with p_wait_states = 0: on accept at edge N, go to RESP; dbus_ack high in cycle N+1; dbus_busy never asserted.
REQ-018 SHALL, with p_wait_states = W > 0: on accept, go to WAIT for exactly W cycles with dbus_busy high, then RESP with dbus_ack high in cycle N+W+1.
REQ-019 SHALL keep dbus_busy low in IDLE and RESP; requests presented while busy are ignored, and no queueing occurs.
REQ-020 SHALL, from RESP: on a new request, accept it (back-to-back, one transfer per cycle at W=0); otherwise go to IDLE.
REQ-021 SHALL commit a write on the edge that enters RESP; byte lanes with be=0 are unchanged; be=0000 still acks.
REQ-022 SHALL, on a read, drive dbus_rd_data with the word at the captured index in the RESP cycle and hold it until the next read response; a write response leaves dbus_rd_data unchanged.
REQ-023 SHALL treat rd_en and wr_en both high as a write; dbus_rd_data is unchanged.
REQ-024 SHALL compute index as addr[31:2]; if index >= p_depth, drop the write, return 32'h0 for a read, still ack, and set o_addr_err.
REQ-025 SHALL ensure a read to an address written in the immediately preceding transfer returns the new data.

Reset
REQ-026 SHALL, while i_rst is high at an edge: state=IDLE, dbus_ack=0, dbus_busy=0, dbus_rd_data=32'h0, o_addr_err=0.
REQ-027 SHALL, on reset mid-access (in WAIT), abandon the pending transfer: no write commit, no ack.
REQ-028 SHALL NOT reset RAM contents.

Structure
REQ-029 SHALL define state enum dbus_resp_state_e in shared package pck_dbus, alongside the constant DBUS_MAX_WAIT = 15.
REQ-030 SHALL instantiate sub-module ram_sp_be (single-port, synchronous, byte-enable write, registered read), parameterised by depth.

Verification
REQ-031 SHALL verify: W=0, write 0xDEADBEEF to 0x10 with be=1111, then read 0x10 -> ack at each N+1, rd_data=0xDEADBEEF, busy never high.
REQ-032 SHALL verify: write 0xAABBCCDD to 0x20, then be=0100 with data 0x00110000 -> read returns 0xAA11CCDD.
REQ-033 SHALL verify: W=3, read accepted at cycle 0 -> busy high in cycles 1-3, ack in cycle 4 only; a request presented in cycle 2 is ignored.
REQ-034 SHALL verify: p_depth=1024, read of 0x00001000 -> ack, rd_data=0, o_addr_err=1 until reset.
REQ-035 SHALL verify: W=2, write accepted, i_rst in cycle 1 -> no ack, and a later read shows the old word.
REQ-036 SHALL verify: rd_en and wr_en both high with 0x12345678 at 0x4 -> treated as write, rd_data unchanged; a following read returns 0x12345678.
